// File: rtl/sha256_block_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_block_sequencer
//
// Drives the shared sha256_core over a multi-block message. Padded 512-bit
// blocks arrive from the SPI register file over valid/ready. Each block gets
// one core start: the first block of a message loads the IV, later blocks
// chain from the previous digest. The digest of the last block is latched
// and a one-cycle done interrupt is raised.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start, i_abort    one-cycle control pulses (new message / abandon)
//   i_blk_valid/o_blk_ready, i_blk_data, i_blk_last   block input handshake
//   o_core_start, o_core_init, o_core_block           core request
//   i_core_done, i_core_digest                        core response
//   o_digest, o_digest_valid, o_irq_done              final result
//   o_busy, o_err, o_blk_count                        status
//
// All outputs are registered. They are computed from the next state, so they
// take effect in the cycle that state is entered.
// ---------------------------------------------------------------------------
module sha256_block_sequencer #(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [511:0]     i_blk_data,
    input  logic             i_blk_last,
    output logic             o_core_start,
    output logic             o_core_init,
    output logic [511:0]     o_core_block,
    input  logic             i_core_done,
    input  logic [255:0]     i_core_digest,
    output logic [255:0]     o_digest,
    output logic             o_digest_valid,
    output logic             o_irq_done,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_blk_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_ISSUE,
        S_WAIT_CORE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [511:0]       blk_q, blk_d;
    logic               init_q, init_d;
    logic               start_q, start_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               dv_q, dv_d;
    logic               irq_q, irq_d;
    logic [255:0]       digest_q, digest_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        timer_d  = timer_q;
        blk_d    = blk_q;
        err_d    = err_q;
        dv_d     = dv_q;
        irq_d    = 1'b0;
        digest_d = digest_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d = S_WAIT_BLK;
                    count_d = '0;
                    dv_d    = 1'b0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                end
            end
            S_WAIT_BLK: begin
                // o_blk_ready is high throughout this state, so valid alone
                // completes the handshake.
                if (i_blk_valid) begin
                    blk_d   = i_blk_data;
                    last_d  = i_blk_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                first_d = 1'b0;
                state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                timer_d = timer_q + TMR_W'(1);
                // done is checked first so a completion in the timeout cycle
                // still counts as a success.
                if (i_core_done) begin
                    if (count_q == {CNT_W{1'b1}})
                        err_d = 1'b1;
                    else
                        count_d = count_q + CNT_W'(1);
                    if (last_q) begin
                        digest_d = i_core_digest;
                        dv_d     = 1'b1;
                        irq_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_WAIT_BLK;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    dv_d    = 1'b0;
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above, including a block
        // handshake or core completion landing in the same cycle. Only the
        // state and the valid flag move; the sticky error is left alone.
        if (i_abort) begin
            state_d  = S_IDLE;
            dv_d     = 1'b0;
            irq_d    = 1'b0;
            first_d  = first_q;
            last_d   = last_q;
            timer_d  = timer_q;
            blk_d    = blk_q;
            err_d    = err_q;
            digest_d = digest_q;
            count_d  = count_q;
        end
    end

    // Outputs that are pure functions of the state being entered.
    always_comb begin
        ready_d = (state_d == S_WAIT_BLK);
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_WAIT_BLK) || (state_d == S_ISSUE) ||
                  (state_d == S_WAIT_CORE);
        // Init is only reloaded on entry to ISSUE so it stays stable while
        // the core is working on the block.
        init_d  = (state_d == S_ISSUE) ? first_q : init_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            timer_q  <= '0;
            blk_q    <= '0;
            init_q   <= 1'b0;
            start_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            dv_q     <= 1'b0;
            irq_q    <= 1'b0;
            digest_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            blk_q    <= blk_d;
            init_q   <= init_d;
            start_q  <= start_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            dv_q     <= dv_d;
            irq_q    <= irq_d;
            digest_q <= digest_d;
            count_q  <= count_d;
        end
    end

    assign o_blk_ready    = ready_q;
    assign o_core_start   = start_q;
    assign o_core_init    = init_q;
    assign o_core_block   = blk_q;
    assign o_digest       = digest_q;
    assign o_digest_valid = dv_q;
    assign o_irq_done     = irq_q;
    assign o_busy         = busy_q;
    assign o_err          = err_q;
    assign o_blk_count    = count_q;

endmodule
